// File: rtl/decode_pkg.sv
// decode_pkg: RV32I opcodes, format enum and the decoded bundle shared by the decode stage.
package decode_pkg;
    localparam int DEC_XLEN = 32;
    localparam int DEC_AW   = 5;
    localparam logic [6:0] OP       = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] LOAD     = 7'b0000011;
    localparam logic [6:0] STORE    = 7'b0100011;
    localparam logic [6:0] BRANCH   = 7'b1100011;
    localparam logic [6:0] JAL      = 7'b1101111;
    localparam logic [6:0] JALR     = 7'b1100111;
    localparam logic [6:0] LUI      = 7'b0110111;
    localparam logic [6:0] AUIPC    = 7'b0010111;
    localparam logic [6:0] SYSTEM   = 7'b1110011;
    localparam logic [6:0] MISC_MEM = 7'b0001111;
    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_e;
    typedef struct packed {
        logic [6:0]          opcode;
        logic [2:0]          funct3;
        logic [6:0]          funct7;
        logic [DEC_AW-1:0]   rs1;
        logic [DEC_AW-1:0]   rs2;
        logic [DEC_AW-1:0]   rd;
        logic [DEC_XLEN-1:0] imm;
        fmt_e                fmt;
        logic                rs1_used;
        logic                rs2_used;
        logic                rd_we;
        logic                illegal;
    } decoded_t;
endpackage

// File: rtl/decode_comb.sv
// decode_comb: pure combinational RV32I field extraction, format classification and illegal check.
module decode_comb
    import decode_pkg::*;
(
    input  logic [31:0] i_insn,
    output decoded_t    o_dec
);
    logic [6:0]  w_f7;
    logic [2:0]  w_f3;
    logic [31:0] w_imm;
    fmt_e        w_fmt;
    logic        w_bad;
    assign w_f7 = i_insn[31:25];
    assign w_f3 = i_insn[14:12];
    always_comb begin
        w_fmt = FMT_R;
        w_bad = 1'b0;
        case (i_insn[6:0])
            OP:               w_bad = !(w_f7 == 7'h00 || (w_f7 == 7'h20 && (w_f3 == 3'b000 || w_f3 == 3'b101)));
            OP_IMM: begin
                w_fmt = FMT_I;
                w_bad = (w_f3 == 3'b001 && w_f7 != 7'h00) || (w_f3 == 3'b101 && w_f7 != 7'h00 && w_f7 != 7'h20);
            end
            LOAD: begin
                w_fmt = FMT_I;
                w_bad = w_f3 == 3'b011 || w_f3[2:1] == 2'b11;
            end
            JALR: begin
                w_fmt = FMT_I;
                w_bad = w_f3 != 3'b000;
            end
            SYSTEM, MISC_MEM: w_fmt = FMT_I;
            STORE: begin
                w_fmt = FMT_S;
                w_bad = w_f3 >= 3'b011;
            end
            BRANCH: begin
                w_fmt = FMT_B;
                w_bad = w_f3[2:1] == 2'b01;
            end
            LUI, AUIPC:       w_fmt = FMT_U;
            JAL:              w_fmt = FMT_J;
            default:          w_bad = 1'b1;
        endcase
    end
    // Unknown opcodes classify as R, so they also carry a zero immediate.
    assign w_imm = (w_fmt == FMT_I) ? {{20{i_insn[31]}}, i_insn[31:20]} :
                   (w_fmt == FMT_S) ? {{20{i_insn[31]}}, i_insn[31:25], i_insn[11:7]} :
                   (w_fmt == FMT_B) ? {{19{i_insn[31]}}, i_insn[31], i_insn[7], i_insn[30:25], i_insn[11:8], 1'b0} :
                   (w_fmt == FMT_U) ? {i_insn[31:12], 12'b0} :
                   (w_fmt == FMT_J) ? {{11{i_insn[31]}}, i_insn[31], i_insn[19:12], i_insn[20], i_insn[30:21], 1'b0} :
                   32'b0;
    assign o_dec = '{
        opcode:   i_insn[6:0],
        funct3:   w_f3,
        funct7:   w_f7,
        rs1:      i_insn[19:15],
        rs2:      i_insn[24:20],
        rd:       i_insn[11:7],
        imm:      w_imm,
        fmt:      w_fmt,
        rs1_used: !w_bad && (w_fmt inside {FMT_R, FMT_I, FMT_S, FMT_B}),
        rs2_used: !w_bad && (w_fmt inside {FMT_R, FMT_S, FMT_B}),
        rd_we:    !w_bad && i_insn[11:7] != 5'd0 && (w_fmt inside {FMT_R, FMT_I, FMT_U, FMT_J}),
        illegal:  w_bad
    };
endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decode with a valid/ready handshake and a 2-entry skid buffer.
module decode_stage
    import decode_pkg::*;
#(
    parameter int INSN_WIDTH = 32,
    parameter int XLEN       = 32,
    parameter int PC_WIDTH   = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [INSN_WIDTH-1:0] in_insn,
    input  logic [PC_WIDTH-1:0]   in_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PC_WIDTH-1:0]   out_pc,
    output logic [6:0]            out_opcode,
    output logic [2:0]            out_funct3,
    output logic [6:0]            out_funct7,
    output logic [ADDR_WIDTH-1:0] out_rs1,
    output logic [ADDR_WIDTH-1:0] out_rs2,
    output logic [ADDR_WIDTH-1:0] out_rd,
    output logic [XLEN-1:0]       out_imm,
    output logic [2:0]            out_fmt,
    output logic                  out_rs1_used,
    output logic                  out_rs2_used,
    output logic                  out_rd_we,
    output logic                  out_illegal
);
    decoded_t              w_dec;
    decoded_t              r_main;
    decoded_t              r_skid;
    logic [PC_WIDTH-1:0]   r_main_pc;
    logic [PC_WIDTH-1:0]   r_skid_pc;
    logic                  r_main_valid;
    logic                  r_skid_valid;
    logic                  w_acc;
    logic                  w_adv;
    decode_comb u_decode_comb (
        .i_insn (in_insn),
        .o_dec  (w_dec)
    );
    assign in_ready = !r_skid_valid;
    assign w_acc    = in_valid && in_ready;
    assign w_adv    = !r_main_valid || out_ready;
    // Skid only fills while main is held, and in_ready is low whenever it is full,
    // so a draining skid never competes with a new input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main       <= '0;
            r_skid       <= '0;
            r_main_pc    <= '0;
            r_skid_pc    <= '0;
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (flush_i) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_adv) begin
            if (r_skid_valid) begin
                r_main       <= r_skid;
                r_main_pc    <= r_skid_pc;
                r_main_valid <= 1'b1;
                r_skid_valid <= 1'b0;
            end else begin
                r_main_valid <= w_acc;
                if (w_acc) begin
                    r_main    <= w_dec;
                    r_main_pc <= in_pc;
                end
            end
        end else if (w_acc) begin
            r_skid       <= w_dec;
            r_skid_pc    <= in_pc;
            r_skid_valid <= 1'b1;
        end
    end
    assign out_valid    = r_main_valid;
    assign out_pc       = r_main_pc;
    assign out_opcode   = r_main.opcode;
    assign out_funct3   = r_main.funct3;
    assign out_funct7   = r_main.funct7;
    assign out_rs1      = r_main.rs1;
    assign out_rs2      = r_main.rs2;
    assign out_rd       = r_main.rd;
    assign out_imm      = r_main.imm;
    assign out_fmt      = r_main.fmt;
    assign out_rs1_used = r_main.rs1_used;
    assign out_rs2_used = r_main.rs2_used;
    assign out_rd_we    = r_main.rd_we;
    assign out_illegal  = r_main.illegal;
endmodule
